// File: rtl/adder_issue_buffer.sv
// Issue buffer for adder-class micro-ops: holds renamed ops until their sources are written
// back, then issues the oldest ready entry through a registered valid/ready output stage.
module adder_issue_buffer #(
  parameter  int DP  = 4,
  parameter  int RNB = 2,
  localparam int RW  = 5 + RNB,
  localparam int DW  = 8 + 64 + 64 + 3 * RW,
  localparam int WBW = 32 * (2 ** RNB)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           flush,
  input  logic           adder_buffer_push,
  input  logic [DW-1:0]  adder_dispat_info,
  output logic           adder_buffer_full,
  input  logic [WBW-1:0] wbLog_qout,
  output logic           adder_execute_valid,
  output logic [DW-1:0]  adder_execute_info,
  input  logic           adder_execute_ready
);

  localparam int CW = $clog2(DP + 1);
  localparam int IW = $clog2(DP);

  logic [DW-1:0]  entry_q [DP];
  logic [DW-1:0]  entry_d [DP];
  logic [CW-1:0]  count_q, count_d;
  logic           valid_q, valid_d;
  logic [DW-1:0]  info_q, info_d;

  logic [DP-1:0]  ready_vec;
  logic           any_ready;
  logic [IW-1:0]  sel_idx;
  logic           slot_free;
  logic           issue;
  logic           push_ok;
  logic [CW-1:0]  wr_idx;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
  endfunction

  // A rename field {arch, ver} is directly the physical register index into wbLog.
  function automatic logic src_ok(input logic [RW-1:0] f, input logic [WBW-1:0] wb);
    return (f[RW-1:RNB] == 5'd0) || wb[f];
  endfunction

  // Opcode order {lui,auipc,addi,addiw,add,addw,sub,subw}; malformed opcodes need no sources.
  function automatic logic entry_ready(input logic [7:0]     op,
                                       input logic [RW-1:0]  rs1,
                                       input logic [RW-1:0]  rs2,
                                       input logic [WBW-1:0] wb);
    logic need1;
    logic need2;
    need2 = is_onehot(op) && (|op[3:0]);
    need1 = need2 || (is_onehot(op) && (|op[5:4]));
    return (!need1 || src_ok(rs1, wb)) && (!need2 || src_ok(rs2, wb));
  endfunction

  always_comb begin : p_ready
    ready_vec = '0;
    for (int i = 0; i < DP; i++) begin
      ready_vec[i] = (CW'(i) < count_q) &&
                     entry_ready(entry_q[i][DW-1 -: 8], entry_q[i][2*RW-1 -: RW],
                                 entry_q[i][RW-1:0], wbLog_qout);
    end
  end

  always_comb begin : p_select
    any_ready = 1'b0;
    sel_idx   = '0;
    for (int i = DP - 1; i >= 0; i--) begin
      if (ready_vec[i]) begin
        any_ready = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  assign adder_buffer_full = (count_q == CW'(DP));
  assign slot_free         = !valid_q || adder_execute_ready;
  assign issue             = slot_free && any_ready;
  assign push_ok           = adder_buffer_push && !adder_buffer_full;
  assign wr_idx            = count_q - CW'(issue);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : p_next
    entry_d = entry_q;
    count_d = count_q + CW'(push_ok) - CW'(issue);
    valid_d = slot_free ? any_ready : valid_q;
    info_d  = issue ? entry_q[sel_idx] : info_q;
    if (issue) begin
      for (int i = 0; i < DP - 1; i++) begin
        if (IW'(i) >= sel_idx) entry_d[i] = entry_q[i + 1];
      end
    end
    if (push_ok) entry_d[wr_idx[IW-1:0]] = adder_dispat_info;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      valid_q <= 1'b0;
      info_q  <= '0;
    end else if (flush) begin
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      info_q  <= info_d;
    end
  end

  // NOTE: payload storage has no reset; count_q alone decides which entries are live.
  always_ff @(posedge CLK) begin
    entry_q <= entry_d;
  end

  assign adder_execute_valid = valid_q;
  assign adder_execute_info  = info_q;

  a_opcode_onehot: assert property (@(posedge CLK) disable iff (RST || flush)
    push_ok |-> is_onehot(adder_dispat_info[DW-1 -: 8]));

endmodule
